nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 13 +
 rtl/nibble_serial_add_ctrl_cla4_slice.sv | 31 +++
 rtl/nibble_serial_add_ctrl.sv | 104 ++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// Holds the FSM state encoding and the width of the shared adder slice.
package nibble_serial_add_ctrl_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_cla4_slice.sv
// 4-bit carry-lookahead adder slice: propagate/generate terms feed
// flattened carry equations so no carry ripples through the slice.
module cla4_slice
   import nibble_serial_add_ctrl_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout
);

   logic [SLICE_W-1:0] p;
   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] c;

   always_comb begin
      p = a ^ b;
      g = a & b;
      c[0] = g[0] | (p[0] & cin);
      c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
      c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
   end

   assign s    = p ^ {c[SLICE_W-2:0], cin};
   assign cout = c[SLICE_W-1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Serial W-bit adder/subtractor: one shared 4-bit CLA slice is walked over
// the operands LSB nibble first, with the carry chained through a flop.
module nibble_serial_add_ctrl
   import nibble_serial_add_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SLICE_W*NIBBLES-1:0] a,
   input  logic [SLICE_W*NIBBLES-1:0] b,
   input  logic                       cin,
   input  logic                       sub,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SLICE_W*NIBBLES-1:0] sum,
   output logic                       cout,
   output logic                       ovf
);

   localparam int W     = SLICE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [W-1:0]       op_a_q, op_a_d;
   logic [W-1:0]       op_b_q, op_b_d;
   logic [W-1:0]       sum_q, sum_d;

   logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
   logic               sl_co;

   assign sl_a = op_a_q[int'(idx_q)*SLICE_W +: SLICE_W];
   assign sl_b = op_b_q[int'(idx_q)*SLICE_W +: SLICE_W];

   cla4_slice u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry_q),
      .s    (sl_s),
      .cout (sl_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         sum_q   <= sum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (idx_q == IDX_LAST) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Subtraction is folded in at accept time: B is inverted and the +1
   // enters as the initial carry, so RUN only ever adds.
   always_comb begin
      idx_d   = idx_q;
      carry_d = carry_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sum_d   = sum_q;
      if (state_q == IDLE && in_valid) begin
         op_a_d  = a;
         op_b_d  = sub ? ~b : b;
         carry_d = sub ? 1'b1 : cin;
         idx_d   = '0;
      end else if (state_q == RUN) begin
         sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = sl_s;
         carry_d = sl_co;
         idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      sum       = sum_q;
      cout      = carry_q;
      ovf       = (op_a_q[W-1] == op_b_q[W-1]) && (sum_q[W-1] != op_a_q[W-1]);
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl: expected results come from an
// integer-arithmetic model and are checked by a monitor on output handshakes.
module tb_nibble_serial_add_ctrl;

   localparam int NIBBLES = 4;
   localparam int W = 4 * NIBBLES;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, cout, ovf;
   logic [W-1:0] sum;

   int   checks = 0;
   int   failures = 0;
   exp_t exp_mem [0:511];
   int   wr_ptr = 0;
   int   rd_ptr = 0;
   bit   rand_rdy = 1'b0;
   bit   force_rdy = 1'b1;

   nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Reference: plain signed/unsigned integer arithmetic on the operands.
   function automatic exp_t model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                  input logic cin_i, input logic sub_i);
      exp_t   e;
      longint ua, ub, sa, sb, ci, ur, sr;
      longint smax, smin;
      ua = a_i;
      ub = b_i;
      sa = $signed(a_i);
      sb = $signed(b_i);
      ci = cin_i;
      smax = (longint'(1) <<< (W - 1)) - 1;
      smin = -(longint'(1) <<< (W - 1));
      if (sub_i) begin
         ur = ua - ub;
         sr = sa - sb;
         e.cout = (ua >= ub);
      end else begin
         ur = ua + ub + ci;
         sr = sa + sb + ci;
         e.cout = (ur >= (longint'(1) <<< W));
      end
      e.sum = ur[W-1:0];
      e.ovf = (sr > smax) || (sr < smin);
      return e;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid)
            check("in_ready_low_while_valid", in_ready, 0);
         if (!rst && out_valid && out_ready) begin
            check("result_expected", wr_ptr > rd_ptr, 1);
            if (wr_ptr > rd_ptr) begin
               e = exp_mem[rd_ptr];
               rd_ptr++;
               check("sum", sum, e.sum);
               check("cout", cout, e.cout);
               check("ovf", ovf, e.ovf);
            end
         end
      end
   endtask

   task automatic ready_driver();
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the accept edge, or of
   // edge accept+NIBBLES when the latency check is requested.
   task automatic do_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic cin_i, input logic sub_i, input bit chk_lat);
      bit acc = 0;
      bit lat_ok = 1;
      in_valid = 1'b1;
      a = a_i;
      b = b_i;
      cin = cin_i;
      sub = sub_i;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1;
            exp_mem[wr_ptr] = model(a_i, b_i, cin_i, sub_i);
            wr_ptr++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("accepted", acc, 1);
      if (acc && chk_lat) begin
         for (int j = 1; j <= NIBBLES; j++) begin
            // scramble operands during RUN; they must not matter
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
            if (j < NIBBLES && out_valid) lat_ok = 0;
            if (j == NIBBLES && !out_valid) lat_ok = 0;
         end
         check("latency", lat_ok, 1);
      end
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(posedge clk);
         #1;
         ok = in_ready && (rd_ptr == wr_ptr);
      end
      check("reach_idle", ok, 1);
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      logic [W-1:0] h_sum;
      logic         h_cout, h_ovf;
      bit           ok, quiet;
      fork
         monitor();
         ready_driver();
         begin
            #500000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);

      force_rdy = 1'b1;
      do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1);
      do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);
      do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
      do_op(16'h0003, 16'h0005, 1'b0, 1'b1, 1);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
      do_op(16'h1234, 16'h1234, 1'b1, 1'b1, 1);
      wait_idle();

      // backpressure: result must hold while out_ready stays low
      force_rdy = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1);
      h_sum = sum;
      h_cout = cout;
      h_ovf = ovf;
      ok = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) begin
            in_valid = 1'b1;
            a = 16'hDEAD;
            b = 16'hBEEF;
         end
         if (i == 2) in_valid = 1'b0;
         if (!out_valid || in_ready || sum !== h_sum || cout !== h_cout || ovf !== h_ovf) ok = 0;
      end
      check("hold_stable", ok, 1);
      force_rdy = 1'b1;
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         ok = out_valid && out_ready;
      end
      check("release_handshake", ok, 1);
      @(posedge clk);
      #1;
      check("in_ready_after_consume", in_ready, 1);
      check("out_valid_after_consume", out_valid, 0);

      // abort: reset lands while RUN is on idx 2
      do_op(16'hAAAA, 16'h5555, 1'b0, 1'b0, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      wr_ptr--;
      check("abort_in_ready", in_ready, 1);
      check("abort_sum_cleared", sum, 0);
      quiet = 1;
      for (int i = 0; i < NIBBLES + 4; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) quiet = 0;
      end
      check("abort_no_valid", quiet, 1);
      do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1);
      wait_idle();

      rand_rdy = 1'b1;
      for (int n = 0; n < 60; n++) begin
         do_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rand_rdy = 1'b0;
      force_rdy = 1'b1;
      wait_idle();
      check("drain", rd_ptr, wr_ptr);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
